// File: rtl/fp_match_engine.sv
// Template store with sequential match search.
// Enrollment writes templates in ring order. A query latches a probe and scans
// one entry per cycle, from index 0 upward. The result is then held until the
// consumer takes it.
//
// state | meaning
// IDLE  | accepts clear, query or enrollment (in that priority order)
// SCAN  | compares one entry per cycle against the probe
// DONE  | result presented; waits for result_ready
module fp_match_engine #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enroll_valid,
  input  logic [WIDTH-1:0]           enroll_data,
  output logic                       enroll_ready,
  input  logic                       query_valid,
  input  logic [WIDTH-1:0]           query_data,
  output logic                       query_ready,
  input  logic                       clear,
  output logic                       result_valid,
  input  logic                       result_ready,
  output logic                       result_match,
  output logic [$clog2(DEPTH)-1:0]   result_index,
  output logic [WIDTH-1:0]           result_data,
  output logic [$clog2(DEPTH):0]     entry_count
);

  localparam int IW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t            state, state_nxt;
  logic [WIDTH-1:0]  store [DEPTH];
  logic [DEPTH-1:0]  valid;
  logic [IW-1:0]     wr_ptr;
  logic [IW-1:0]     scan_idx;
  logic [WIDTH-1:0]  probe;
  logic              hit;
  logic              scan_last;
  logic              query_fire;
  logic              enroll_fire;

  assign hit         = valid[scan_idx] && (store[scan_idx] == probe);
  assign scan_last   = (scan_idx == IW'(DEPTH - 1));
  assign query_fire  = query_valid && query_ready;
  assign enroll_fire = enroll_valid && enroll_ready;
  assign result_data = probe;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (query_fire) state_nxt = SCAN;
      SCAN:    if (hit || scan_last) state_nxt = DONE;
      DONE:    if (result_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs; a pending query blocks enrollment
  always_comb begin
    query_ready  = (state == IDLE) && !clear;
    enroll_ready = (state == IDLE) && !clear && !query_valid;
    result_valid = (state == DONE);
  end

  // Template data array; contents survive reset, validity lives in valid[]
  always_ff @(posedge clk) begin
    if (enroll_fire) store[wr_ptr] <= enroll_data;
  end

  // Bookkeeping, probe capture and scan result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid        <= '0;
      wr_ptr       <= '0;
      entry_count  <= '0;
      probe        <= '0;
      scan_idx     <= '0;
      result_match <= 1'b0;
      result_index <= '0;
    end else begin
      if (state == IDLE && clear) begin
        valid       <= '0;
        wr_ptr      <= '0;
        entry_count <= '0;
      end else if (enroll_fire) begin
        valid[wr_ptr] <= 1'b1;
        wr_ptr        <= wr_ptr + IW'(1);
        if (entry_count != (IW+1)'(DEPTH)) entry_count <= entry_count + (IW+1)'(1);
      end

      if (query_fire) begin
        probe    <= query_data;
        scan_idx <= '0;
      end else if (state == SCAN) begin
        scan_idx <= scan_idx + IW'(1);
        if (hit) begin
          result_match <= 1'b1;
          result_index <= scan_idx;
        end else if (scan_last) begin
          result_match <= 1'b0;
          result_index <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_fp_match_engine.sv
// Directed bench for fp_match_engine (DEPTH=16, WIDTH=8).
module tb_fp_match_engine;

  logic       clk = 1'b0;
  logic       rst;
  logic       enroll_valid;
  logic [7:0] enroll_data;
  logic       enroll_ready;
  logic       query_valid;
  logic [7:0] query_data;
  logic       query_ready;
  logic       clear;
  logic       result_valid;
  logic       result_ready;
  logic       result_match;
  logic [3:0] result_index;
  logic [7:0] result_data;
  logic [4:0] entry_count;

  int passed = 0;
  int total  = 0;
  int lat;

  fp_match_engine #(.DEPTH(16), .WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .enroll_valid(enroll_valid), .enroll_data(enroll_data), .enroll_ready(enroll_ready),
    .query_valid(query_valid), .query_data(query_data), .query_ready(query_ready),
    .clear(clear),
    .result_valid(result_valid), .result_ready(result_ready),
    .result_match(result_match), .result_index(result_index), .result_data(result_data),
    .entry_count(entry_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic enroll(input logic [7:0] d);
    enroll_valid = 1'b1;
    enroll_data  = d;
    step();
    enroll_valid = 1'b0;
  endtask

  // Offers a probe and returns after the acceptance edge
  task automatic start_query(input string tag, input logic [7:0] d);
    query_valid = 1'b1;
    query_data  = d;
    check({tag, "_qready"}, query_ready, 1'b1);
    step();
    query_valid = 1'b0;
  endtask

  // Counts edges since acceptance until result_valid, bounded
  task automatic wait_res(input int start, output int n);
    n = start;
    while (!result_valid && n < 40) begin
      step();
      n++;
    end
  endtask

  task automatic release_res();
    result_ready = 1'b1;
    step();
    result_ready = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  task automatic query_check(input string tag, input logic [7:0] d, input int exp_lat,
                             input logic exp_match, input logic [3:0] exp_idx);
    start_query(tag, d);
    wait_res(0, lat);
    check({tag, "_lat"},   lat, exp_lat);
    check({tag, "_valid"}, result_valid, 1'b1);
    check({tag, "_match"}, result_match, exp_match);
    check({tag, "_index"}, result_index, exp_idx);
    check({tag, "_data"},  result_data, d);
    release_res();
    check({tag, "_idle"},  result_valid, 1'b0);
  endtask

  initial begin
    rst = 1'b1; enroll_valid = 1'b0; enroll_data = '0; query_valid = 1'b0;
    query_data = '0; clear = 1'b0; result_ready = 1'b0;
    #1;
    check("rst_valid", result_valid, 1'b0);
    check("rst_count", entry_count, 5'd0);
    check("rst_match", result_match, 1'b0);
    check("rst_index", result_index, 4'd0);
    check("rst_data",  result_data, 8'h00);
    step(); step();
    rst = 1'b0;
    step();
    check("idle_qready", query_ready, 1'b1);
    check("idle_eready", enroll_ready, 1'b1);

    // Empty store: fixed 16-cycle miss
    query_check("empty", 8'h5A, 16, 1'b0, 4'd0);

    // Basic hit at index 1
    enroll(8'h11); enroll(8'h22); enroll(8'h33);
    check("basic_count", entry_count, 5'd3);
    query_check("basic", 8'h22, 2, 1'b1, 4'd1);

    // Clear in IDLE blocks handshakes and empties the store
    clear = 1'b1;
    #1;
    check("clr_qready", query_ready, 1'b0);
    check("clr_eready", enroll_ready, 1'b0);
    step();
    clear = 1'b0;
    check("clr_count", entry_count, 5'd0);

    // Lowest index wins; result held while consumer stalls
    enroll(8'h44); enroll(8'h55); enroll(8'h44);
    start_query("hold", 8'h44);
    wait_res(0, lat);
    check("hold_lat", lat, 1);
    for (int i = 0; i < 5; i++) begin
      step();
      check("hold_valid", result_valid, 1'b1);
      check("hold_match", result_match, 1'b1);
      check("hold_index", result_index, 4'd0);
      check("hold_data",  result_data, 8'h44);
    end
    release_res();
    check("hold_idle_valid", result_valid, 1'b0);
    check("hold_idle_qready", query_ready, 1'b1);

    // Query beats enrollment; clear and enrollment ignored during scan
    query_valid  = 1'b1;
    query_data   = 8'h55;
    enroll_valid = 1'b1;
    enroll_data  = 8'h99;
    #1;
    check("prio_eready", enroll_ready, 1'b0);
    check("prio_qready", query_ready, 1'b1);
    step();
    query_valid = 1'b0;
    clear       = 1'b1;
    check("scan_eready", enroll_ready, 1'b0);
    check("scan_qready", query_ready, 1'b0);
    step();
    clear = 1'b0;
    check("scan_count", entry_count, 5'd3);
    wait_res(1, lat);
    check("prio_lat",   lat, 2);
    check("prio_match", result_match, 1'b1);
    check("prio_index", result_index, 4'd1);
    check("done_eready", enroll_ready, 1'b0);
    release_res();
    check("after_eready", enroll_ready, 1'b1);
    enroll_valid = 1'b0;
    check("prio_count", entry_count, 5'd3);

    // Ring overwrite: 17 enrollments, 0x10 replaces 0x00 at index 0
    do_clear();
    for (int i = 0; i < 17; i++) enroll(8'(i));
    check("ring_count", entry_count, 5'd16);
    query_check("ring_old",  8'h00, 16, 1'b0, 4'd0);
    query_check("ring_new",  8'h10, 1,  1'b1, 4'd0);
    query_check("ring_idx1", 8'h01, 2,  1'b1, 4'd1);
    query_check("ring_last", 8'h0F, 16, 1'b1, 4'd15);

    // Asynchronous reset mid-scan
    start_query("rstscan", 8'h05);
    step();
    check("rstscan_busy", result_valid, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check("rstscan_valid", result_valid, 1'b0);
    check("rstscan_count", entry_count, 5'd0);
    check("rstscan_qready", query_ready, 1'b1);
    #1;
    rst = 1'b0;
    step();
    query_check("postrst", 8'h05, 16, 1'b0, 4'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
